// File: rtl/result_output_serializer.sv
// Result FIFO that emits each buffered (X, Y) pair as one beat (real) or two beats (complex).
// All outputs come from registered state; a complex head is popped only after its Y beat.
module result_output_serializer #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       srst,
    input  logic                       enable,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 format,
    input  logic [W-1:0]               X_in,
    input  logic [W-1:0]               Y_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               data_out,
    output logic [1:0]                 out_format,
    output logic                       out_imag,
    output logic                       out_last,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PtrOne  = AW'(1);
    localparam logic [AW:0]   LvlOne  = (AW + 1)'(1);
    localparam logic [AW:0]   LvlFull = (AW + 1)'(DEPTH);

    typedef enum logic {PhRe, PhIm} phase_e;

    logic [1:0]   fmt_mem [DEPTH];
    logic [W-1:0] x_mem   [DEPTH];
    logic [W-1:0] y_mem   [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    phase_e        phase_q, phase_d;

    logic       push, beat, pop;
    logic [1:0] head_fmt;

    assign head_fmt  = fmt_mem[rd_ptr_q];
    assign out_valid = (level_q != '0);
    assign in_ready  = (level_q < LvlFull);
    assign level     = level_q;

    // Outputs are forced to zero while empty so stale storage never shows.
    always_comb begin
        data_out   = '0;
        out_format = 2'd0;
        out_imag   = 1'b0;
        out_last   = 1'b0;
        if (out_valid) begin
            out_format = head_fmt;
            if (phase_q == PhIm) begin
                data_out = y_mem[rd_ptr_q];
                out_imag = 1'b1;
                out_last = 1'b1;
            end else begin
                data_out = x_mem[rd_ptr_q];
                out_last = ~head_fmt[1];
            end
        end
    end

    always_comb begin
        push     = enable & in_valid & in_ready;
        beat     = enable & out_valid & out_ready;
        pop      = beat & out_last;
        wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
        phase_d  = phase_q;
        if (beat) begin
            phase_d = pop ? PhRe : PhIm;
        end
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LvlOne;
            2'b01:   level_d = level_q - LvlOne;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            phase_q  <= PhRe;
        end else if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            phase_q  <= PhRe;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            phase_q  <= phase_d;
        end
    end

    // Storage needs no reset: contents are only observed while level is non-zero.
    always_ff @(posedge clk) begin
        if (push && !srst) begin
            fmt_mem[wr_ptr_q] <= format;
            x_mem[wr_ptr_q]   <= X_in;
            y_mem[wr_ptr_q]   <= Y_in;
        end
    end

endmodule
